// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one WIDTH-bit word per valid/ready handshake,
// shifted out MSB-first with an optional forced idle gap between words.
module piso_serializer #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LOAD = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       gapcnt_q, gapcnt_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sout_last_q, sout_last_d;

    logic last_bit;
    logic handshake;

    assign last_bit  = (state_q == S_SHIFT) && (bitcnt_q == '0);
    // Ready is gated by reset so upstream never sees a handshake while held in reset.
    assign din_ready = rst && ((state_q == S_IDLE) || (last_bit && (GAP == 0)));
    assign handshake = din_valid && din_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d  = S_SHIFT;
                    shreg_d  = din;
                    bitcnt_d = LAST_IDX;
                end
            end
            S_SHIFT: begin
                // Zero fill leaves the register clear once a word has fully drained.
                shreg_d = shreg_q << 1;
                if (bitcnt_q != '0) begin
                    bitcnt_d = bitcnt_q - CW'(1);
                end else if (GAP > 0) begin
                    state_d  = S_GAP;
                    gapcnt_d = GAP_LOAD;
                end else if (handshake) begin
                    shreg_d  = din;
                    bitcnt_d = LAST_IDX;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gapcnt_d = gapcnt_q - 4'd1;
                if (gapcnt_q <= 4'd1) begin
                    state_d  = S_IDLE;
                    gapcnt_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sout_valid_d = (state_d == S_SHIFT);
        sout_last_d  = sout_valid_d && (bitcnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            gapcnt_q     <= '0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            gapcnt_q     <= gapcnt_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    assign sout       = shreg_q[WIDTH-1];
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Table-driven bench for piso_serializer: three instances (W4/G0, W4/G2, W8/G0)
// with a reference SIPO per instance reassembling the serial stream.
module tb_piso_serializer;

    typedef struct {
        logic       valid;
        logic [7:0] din;
        logic [4:0] exp;       // {din_ready, sout, sout_valid, sout_last, busy}
        logic       chk_sipo;
        logic [7:0] exp_sipo;
    } vec_t;

    logic clk;
    logic rst;

    logic [3:0] din0, din1;
    logic [7:0] din2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       s0, s1, s2;
    logic       sv0, sv1, sv2;
    logic       l0, l1, l2;
    logic       b0, b1, b2;

    logic [7:0] sipo0, sipo1, sipo2;

    int n_vec;
    int n_err;

    piso_serializer #(.WIDTH(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(r0),
        .sout(s0), .sout_valid(sv0), .sout_last(l0), .busy(b0)
    );

    piso_serializer #(.WIDTH(4), .GAP(2)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(r1),
        .sout(s1), .sout_valid(sv1), .sout_last(l1), .busy(b1)
    );

    piso_serializer #(.WIDTH(8), .GAP(0)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(r2),
        .sout(s2), .sout_valid(sv2), .sout_last(l2), .busy(b2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream SIPO models: capture sout on every edge where sout_valid is high.
    always @(posedge clk) if (sv0) sipo0 <= {sipo0[6:0], s0};
    always @(posedge clk) if (sv1) sipo1 <= {sipo1[6:0], s1};
    always @(posedge clk) if (sv2) sipo2 <= {sipo2[6:0], s2};

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [4:0] e,
                                input logic c = 1'b0, input logic [7:0] s = 8'h00);
        vec_t r;
        r.valid    = v;
        r.din      = d;
        r.exp      = e;
        r.chk_sipo = c;
        r.exp_sipo = s;
        return r;
    endfunction

    function automatic logic [4:0] get_out(input int which);
        case (which)
            0:       return {r0, s0, sv0, l0, b0};
            1:       return {r1, s1, sv1, l1, b1};
            default: return {r2, s2, sv2, l2, b2};
        endcase
    endfunction

    function automatic logic [7:0] get_sipo(input int which);
        case (which)
            0:       return {4'h0, sipo0[3:0]};
            1:       return {4'h0, sipo1[3:0]};
            default: return sipo2;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [7:0] d);
        case (which)
            0:       begin v0 = v; din0 = d[3:0]; end
            1:       begin v1 = v; din1 = d[3:0]; end
            default: begin v2 = v; din2 = d;      end
        endcase
    endtask

    task automatic run_row(input int which, input int idx, input vec_t vec);
        string tag;
        tag = $sformatf("dut%0d row%0d", which, idx);
        drive(which, vec.valid, vec.din);
        @(negedge clk);
        check({tag, " outs"}, {3'b000, get_out(which)}, {3'b000, vec.exp});
        if (vec.chk_sipo) check({tag, " sipo"}, get_sipo(which), vec.exp_sipo);
        @(posedge clk);
        #1;
    endtask

    vec_t t0[24];
    vec_t t1[15];
    vec_t t2[10];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        din0 = '0; din1 = '0; din2 = '0;
        sipo0 = '0; sipo1 = '0; sipo2 = '0;

        // GAP=0: single word, back-to-back pair, valid-while-busy with mid-word din change.
        t0[0]  = mk(1, 8'h0B, 5'b10000);
        t0[1]  = mk(0, 8'h00, 5'b01101);
        t0[2]  = mk(0, 8'h00, 5'b00101);
        t0[3]  = mk(0, 8'h00, 5'b01101);
        t0[4]  = mk(0, 8'h00, 5'b11111);
        t0[5]  = mk(1, 8'h0C, 5'b10000, 1, 8'h0B);
        t0[6]  = mk(1, 8'h05, 5'b01101);
        t0[7]  = mk(1, 8'h05, 5'b01101);
        t0[8]  = mk(1, 8'h05, 5'b00101);
        t0[9]  = mk(1, 8'h05, 5'b10111);
        t0[10] = mk(0, 8'h00, 5'b00101, 1, 8'h0C);
        t0[11] = mk(0, 8'h00, 5'b01101);
        t0[12] = mk(0, 8'h00, 5'b00101);
        t0[13] = mk(0, 8'h00, 5'b11111);
        t0[14] = mk(1, 8'h00, 5'b10000, 1, 8'h05);
        t0[15] = mk(1, 8'h0F, 5'b00101);
        t0[16] = mk(1, 8'h06, 5'b00101);
        t0[17] = mk(1, 8'h0F, 5'b00101);
        t0[18] = mk(1, 8'h0F, 5'b10111);
        t0[19] = mk(0, 8'h00, 5'b01101, 1, 8'h00);
        t0[20] = mk(0, 8'h00, 5'b01101);
        t0[21] = mk(0, 8'h00, 5'b01101);
        t0[22] = mk(0, 8'h00, 5'b11111);
        t0[23] = mk(0, 8'h00, 5'b10000, 1, 8'h0F);

        // GAP=2: two idle cycles after each word, then an IDLE cycle for the handshake.
        t1[0]  = mk(1, 8'h09, 5'b10000);
        t1[1]  = mk(1, 8'h06, 5'b01101);
        t1[2]  = mk(1, 8'h06, 5'b00101);
        t1[3]  = mk(1, 8'h06, 5'b00101);
        t1[4]  = mk(1, 8'h06, 5'b01111);
        t1[5]  = mk(1, 8'h06, 5'b00001, 1, 8'h09);
        t1[6]  = mk(1, 8'h06, 5'b00001);
        t1[7]  = mk(1, 8'h06, 5'b10000);
        t1[8]  = mk(0, 8'h00, 5'b00101);
        t1[9]  = mk(0, 8'h00, 5'b01101);
        t1[10] = mk(0, 8'h00, 5'b01101);
        t1[11] = mk(0, 8'h00, 5'b00111);
        t1[12] = mk(0, 8'h00, 5'b00001, 1, 8'h06);
        t1[13] = mk(0, 8'h00, 5'b00001);
        t1[14] = mk(0, 8'h00, 5'b10000);

        // WIDTH=8: 8'hA5 -> 1,0,1,0,0,1,0,1.
        t2[0] = mk(1, 8'hA5, 5'b10000);
        t2[1] = mk(0, 8'h00, 5'b01101);
        t2[2] = mk(0, 8'h00, 5'b00101);
        t2[3] = mk(0, 8'h00, 5'b01101);
        t2[4] = mk(0, 8'h00, 5'b00101);
        t2[5] = mk(0, 8'h00, 5'b00101);
        t2[6] = mk(0, 8'h00, 5'b01101);
        t2[7] = mk(0, 8'h00, 5'b00101);
        t2[8] = mk(0, 8'h00, 5'b11111);
        t2[9] = mk(0, 8'h00, 5'b10000, 1, 8'hA5);

        repeat (2) @(posedge clk);
        #1;
        check("reset dut0", {3'b000, get_out(0)}, 8'h00);
        check("reset dut1", {3'b000, get_out(1)}, 8'h00);
        check("reset dut2", {3'b000, get_out(2)}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready after release", {5'b00000, r0, r1, r2}, 8'h07);
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) run_row(0, i, t0[i]);
        for (int i = 0; i < 15; i++) run_row(1, i, t1[i]);
        for (int i = 0; i < 10; i++) run_row(2, i, t2[i]);

        // Reset after two bits of 4'b1010: outputs clear at once, no residue after release.
        drive(0, 1'b1, 8'h0A);
        @(negedge clk);
        check("midrst ready", {7'b0, r0}, 8'h01);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        check("midrst bit0", {3'b000, get_out(0)}, {3'b000, 5'b01101});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst bit1", {3'b000, get_out(0)}, {3'b000, 5'b00101});
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst async clear", {3'b000, get_out(0)}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("midrst held", {3'b000, get_out(0)}, 8'h00);
        rst = 1'b1;
        #1;
        check("midrst release ready", {3'b000, get_out(0)}, {3'b000, 5'b10000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("midrst residue%0d", i), {3'b000, get_out(0)}, {3'b000, 5'b10000});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
